// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - control sequencer for a shift/add multiply and shift/subtract divide datapath
//
// Purpose: steps an accumulator/ALU datapath through load, clear and N_BITS
// iterations of multiply (op + shift right) or divide (shift left + op).
// All outputs are registered and are a decode of the state being entered.
//
// Ports:
//   i_clk               rising-edge clock
//   i_reset_n           asynchronous active-low reset
//   i_start             request pulse, sampled only in IDLE
//   i_op_sel            0 = multiply, 1 = divide, latched with i_start
//   i_abort             synchronous cancel back to IDLE
//   o_acc_in_select     accumulator loads from the B-register path
//   o_acc_high_select   accumulator high mode: 00 hold, 01 shr, 10 shl, 11 load
//   o_acc_low_select    accumulator low mode, same encoding
//   o_acc_high_reset_p  clear accumulator high half
//   o_op_mul, o_op_div  ALU operation strobes
//   o_busy              high in every state except IDLE
//   o_done              one-cycle completion pulse
module muldiv_sequencer #(
   parameter int N_BITS = 4
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_start,
   input  logic       i_op_sel,
   input  logic       i_abort,
   output logic       o_acc_in_select,
   output logic [1:0] o_acc_high_select,
   output logic [1:0] o_acc_low_select,
   output logic       o_acc_high_reset_p,
   output logic       o_op_mul,
   output logic       o_op_div,
   output logic       o_busy,
   output logic       o_done
);

   localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_LD_HIGH  = 4'd1,
      S_LD_LOW   = 4'd2,
      S_CLR_HIGH = 4'd3,
      S_MUL_OP   = 4'd4,
      S_MUL_SHR  = 4'd5,
      S_DIV_SHL  = 4'd6,
      S_DIV_OP   = 4'd7,
      S_DIV_FIN  = 4'd8,
      S_DONE     = 4'd9
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_count;
   logic            r_op;
   logic [9:0]      r_out;
   state_t          w_next;

   function automatic state_t f_next(input state_t s, input logic start,
                                     input logic abort, input logic op,
                                     input logic [CW-1:0] count);
      state_t n;
      n = S_IDLE;
      if (abort && s != S_IDLE) begin
         n = S_IDLE;
      end else begin
         case (s)
            S_IDLE:     n = (start && !abort) ? S_LD_HIGH : S_IDLE;
            S_LD_HIGH:  n = S_LD_LOW;
            S_LD_LOW:   n = S_CLR_HIGH;
            S_CLR_HIGH: n = op ? S_DIV_SHL : S_MUL_OP;
            S_MUL_OP:   n = S_MUL_SHR;
            S_MUL_SHR:  n = (count == LAST) ? S_DONE : S_MUL_OP;
            S_DIV_SHL:  n = S_DIV_OP;
            S_DIV_OP:   n = (count == LAST) ? S_DIV_FIN : S_DIV_SHL;
            S_DIV_FIN:  n = S_DONE;
            S_DONE:     n = S_IDLE;
            default:    n = S_IDLE;
         endcase
      end
      return n;
   endfunction

   // {acc_in, high[1:0], low[1:0], high_reset, mul, div, done, busy}
   function automatic logic [9:0] f_decode(input state_t s);
      logic [9:0] d;
      case (s)
         S_LD_HIGH:  d = 10'b1_11_00_0_0_0_0_1;
         S_LD_LOW:   d = 10'b0_00_11_0_0_0_0_1;
         S_CLR_HIGH: d = 10'b0_00_00_1_0_0_0_1;
         S_MUL_OP:   d = 10'b0_00_00_0_1_0_0_1;
         S_MUL_SHR:  d = 10'b0_01_01_0_0_0_0_1;
         S_DIV_SHL:  d = 10'b0_10_10_0_0_0_0_1;
         S_DIV_OP:   d = 10'b0_00_00_0_0_1_0_1;
         S_DIV_FIN:  d = 10'b0_00_10_0_0_0_0_1;
         S_DONE:     d = 10'b0_00_00_0_0_0_1_1;
         default:    d = 10'b0;
      endcase
      return d;
   endfunction

   assign w_next = f_next(r_state, i_start, i_abort, r_op, r_count);

   // Outputs are registered from the decode of the state being entered, so
   // they always match r_state without any input-to-output path.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_op    <= 1'b0;
         r_out   <= '0;
      end else begin
         r_state <= w_next;
         r_out   <= f_decode(w_next);
         if (r_state == S_IDLE && i_start && !i_abort) begin
            r_op <= i_op_sel;
         end
         // The last iteration holds the count, so it only wraps via CLR_HIGH.
         if (w_next == S_IDLE || r_state == S_CLR_HIGH) begin
            r_count <= '0;
         end else if ((r_state == S_MUL_SHR || r_state == S_DIV_OP) && r_count != LAST) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign {o_acc_in_select, o_acc_high_select, o_acc_low_select,
           o_acc_high_reset_p, o_op_mul, o_op_div, o_done, o_busy} = r_out;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - randomized self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       op_sel = 1'b0;
   logic       abort = 1'b0;
   logic       acc_in_select;
   logic [1:0] acc_high_select;
   logic [1:0] acc_low_select;
   logic       acc_high_reset_p;
   logic       op_mul;
   logic       op_div;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   muldiv_sequencer #(.N_BITS(N)) dut (
      .i_clk              (clk),
      .i_reset_n          (reset_n),
      .i_start            (start),
      .i_op_sel           (op_sel),
      .i_abort            (abort),
      .o_acc_in_select    (acc_in_select),
      .o_acc_high_select  (acc_high_select),
      .o_acc_low_select   (acc_low_select),
      .o_acc_high_reset_p (acc_high_reset_p),
      .o_op_mul           (op_mul),
      .o_op_div           (op_div),
      .o_busy             (busy),
      .o_done             (done)
   );

   // Expected output words per step: {in, hi, lo, hrst, mul, div, done, busy}
   function automatic logic [9:0] w(input logic in_s, input logic [1:0] hi,
                                    input logic [1:0] lo, input logic hr,
                                    input logic m, input logic d, input logic dn);
      return {in_s, hi, lo, hr, m, d, dn, 1'b1};
   endfunction

   logic [9:0] seq[$];
   bit         m_active = 1'b0;
   int         m_pos = 0;

   // Full expected output trace of one operation, from its step list.
   task automatic build_seq(input logic op);
      seq.delete();
      seq.push_back(w(1, 2'b11, 2'b00, 0, 0, 0, 0));
      seq.push_back(w(0, 2'b00, 2'b11, 0, 0, 0, 0));
      seq.push_back(w(0, 2'b00, 2'b00, 1, 0, 0, 0));
      for (int i = 0; i < N; i++) begin
         if (!op) begin
            seq.push_back(w(0, 2'b00, 2'b00, 0, 1, 0, 0));
            seq.push_back(w(0, 2'b01, 2'b01, 0, 0, 0, 0));
         end else begin
            seq.push_back(w(0, 2'b10, 2'b10, 0, 0, 0, 0));
            seq.push_back(w(0, 2'b00, 2'b00, 0, 0, 1, 0));
         end
      end
      if (op) seq.push_back(w(0, 2'b00, 2'b10, 0, 0, 0, 0));
      seq.push_back(w(0, 2'b00, 2'b00, 0, 0, 0, 1));
   endtask

   function automatic logic [9:0] observed();
      return {acc_in_select, acc_high_select, acc_low_select, acc_high_reset_p,
              op_mul, op_div, done, busy};
   endfunction

   function automatic logic [9:0] expected();
      return m_active ? seq[m_pos] : 10'b0;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // One rising edge: sample the inputs seen by the DUT, advance the model, compare.
   task automatic tick(input string tag);
      logic s, a, o, r;
      @(posedge clk);
      s = start; a = abort; o = op_sel; r = reset_n;
      #1;
      if (!r) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         if (s && !a) begin
            build_seq(o);
            m_active = 1'b1;
            m_pos = 0;
         end
      end else if (a) begin
         m_active = 1'b0;
      end else begin
         m_pos++;
         if (m_pos >= seq.size()) m_active = 1'b0;
      end
      check_eq(tag, 32'(observed()), 32'(expected()));
   endtask

   // Launch one operation and check the edge on which done appears.
   task automatic run_directed(input logic op, input int exp_edge, input string tag);
      int seen_edge;
      int pulses;
      seen_edge = -1;
      pulses = 0;
      start = 1'b1;
      op_sel = op;
      for (int i = 1; i <= 16; i++) begin
         tick(tag);
         if (i == 1) begin
            start = 1'b0;
            op_sel = ~op;
         end
         if (done) begin
            pulses++;
            if (seen_edge < 0) seen_edge = i;
         end
      end
      check_eq({tag, "_done_edge"}, 32'(seen_edge), 32'(exp_edge));
      check_eq({tag, "_done_pulses"}, 32'(pulses), 32'd1);
   endtask

   initial begin
      int pulses;
      #12;
      check_eq("reset_outputs", 32'(observed()), 32'd0);
      reset_n = 1'b1;

      run_directed(1'b0, 12, "mul");
      run_directed(1'b1, 13, "div");

      // Abort sampled on the edge after edge 6 of a multiply.
      start = 1'b1; op_sel = 1'b0;
      tick("abort_pre");
      start = 1'b0;
      for (int i = 2; i <= 6; i++) tick("abort_pre");
      abort = 1'b1;
      tick("abort_idle");
      check_eq("abort_busy", 32'(busy), 32'd0);
      abort = 1'b0;
      run_directed(1'b0, 12, "after_abort");

      // start and abort together in IDLE stay idle.
      start = 1'b1; abort = 1'b1;
      tick("start_abort_idle");
      start = 1'b0; abort = 1'b0;
      tick("start_abort_idle2");

      // Asynchronous reset between edges mid-divide.
      start = 1'b1; op_sel = 1'b1;
      tick("rst_pre");
      start = 1'b0;
      for (int i = 2; i <= 5; i++) tick("rst_pre");
      #2 reset_n = 1'b0;
      #1 check_eq("async_reset", 32'(observed()), 32'd0);
      m_active = 1'b0;
      tick("in_reset");
      #2 reset_n = 1'b1;
      run_directed(1'b1, 13, "after_reset");

      // Start pulsed while busy is ignored.
      pulses = 0;
      start = 1'b1; op_sel = 1'b0;
      tick("busy_start");
      start = 1'b0;
      for (int i = 2; i <= 16; i++) begin
         if (i == 5) begin start = 1'b1; op_sel = 1'b1; end
         if (i == 6) start = 1'b0;
         tick("busy_start");
         if (done) pulses++;
      end
      check_eq("busy_start_pulses", 32'(pulses), 32'd1);

      // Held start: back-to-back with one IDLE cycle between.
      start = 1'b1;
      for (int i = 0; i < 45; i++) begin
         op_sel = 1'($urandom_range(0, 1));
         tick("held_start");
      end
      start = 1'b0;
      for (int i = 0; i < 15; i++) tick("held_drain");

      // Random traffic including aborts and occasional resets.
      for (int i = 0; i < 600; i++) begin
         start   = ($urandom_range(0, 3) == 0);
         op_sel  = 1'($urandom_range(0, 1));
         abort   = ($urandom_range(0, 24) == 0);
         reset_n = ($urandom_range(0, 99) != 0);
         if (!reset_n) begin
            #1 check_eq("rand_async_reset", 32'(observed()), 32'd0);
            m_active = 1'b0;
         end
         tick("random");
      end
      reset_n = 1'b1; start = 1'b0; abort = 1'b0;
      for (int i = 0; i < 16; i++) tick("final_drain");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
